// File: rtl/tlb.sv
// tlb: unified, fully associative TLB of TLBNUM entries, each mapping an
// even/odd virtual page pair. Two independent combinational search ports
// (0 = instruction fetch, 1 = data access) and a combinational read port look
// at registered storage. The storage is updated at the clock edge by the write
// port (TLBWR/TLBFILL) and the invalidate port (INVTLB).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   s{0,1}_vppn/va_bit12/asid  search key (VA[31:13], VA[12], ASID)
//   s{0,1}_found/index/...     search result; all zero on a miss
//   invtlb_valid, invtlb_op    invalidate request; s1_asid/s1_vppn are its operands
//   we, w_index, w_*           entry write
//   r_index, r_*               raw contents of entry r_index
module tlb #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1
);

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic        e;
    logic        g;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    page_t       p0;
    page_t       p1;
  } entry_t;

  entry_t ent_q [TLBNUM];
  entry_t ent_d [TLBNUM];

  // Search keys of both ports packed so one loop serves both.
  logic [1:0][18:0] s_vppn;
  logic [1:0]       s_bit12;
  logic [1:0][9:0]  s_asid;
  assign s_vppn  = {s1_vppn, s0_vppn};
  assign s_bit12 = {s1_va_bit12, s0_va_bit12};
  assign s_asid  = {s1_asid, s0_asid};

  // Per-entry ASID and VA comparisons; port 1 also feeds INVTLB ops 4..6.
  logic [1:0][TLBNUM-1:0] asid_m;
  logic [1:0][TLBNUM-1:0] va_m;

  always_comb begin
    asid_m = '0;
    va_m   = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < TLBNUM; i++) begin
        asid_m[k][i] = (ent_q[i].asid == s_asid[k]);
        // Anything other than a 4 KB page is treated as a 2 MB page.
        if (ent_q[i].ps == 6'd12) va_m[k][i] = (ent_q[i].vppn == s_vppn[k]);
        else                      va_m[k][i] = (ent_q[i].vppn[18:9] == s_vppn[k][18:9]);
      end
    end
  end

  logic [1:0]            s_found;
  logic [1:0][IDXW-1:0]  s_index;
  logic [1:0][5:0]       s_ps;
  page_t [1:0]           s_page;

  // Scanning downward lets the lowest matching index overwrite the others.
  always_comb begin
    s_found = '0;
    s_index = '0;
    s_ps    = '0;
    s_page  = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (ent_q[i].e && (ent_q[i].g || asid_m[k][i]) && va_m[k][i]) begin
          s_found[k] = 1'b1;
          s_index[k] = IDXW'(i);
          s_ps[k]    = ent_q[i].ps;
          if ((ent_q[i].ps == 6'd12) ? s_bit12[k] : s_vppn[k][8]) s_page[k] = ent_q[i].p1;
          else                                                   s_page[k] = ent_q[i].p0;
        end
      end
    end
  end

  assign s0_found = s_found[0];
  assign s0_index = s_index[0];
  assign s0_ps    = s_ps[0];
  assign s0_ppn   = s_page[0].ppn;
  assign s0_plv   = s_page[0].plv;
  assign s0_mat   = s_page[0].mat;
  assign s0_d     = s_page[0].d;
  assign s0_v     = s_page[0].v;
  assign s1_found = s_found[1];
  assign s1_index = s_index[1];
  assign s1_ps    = s_ps[1];
  assign s1_ppn   = s_page[1].ppn;
  assign s1_plv   = s_page[1].plv;
  assign s1_mat   = s_page[1].mat;
  assign s1_d     = s_page[1].d;
  assign s1_v     = s_page[1].v;

  // Invalidate first, then the write, so a colliding write wins its entry.
  always_comb begin
    logic clr;
    ent_d = ent_q;
    clr   = 1'b0;
    if (invtlb_valid) begin
      for (int i = 0; i < TLBNUM; i++) begin
        case (invtlb_op)
          5'd0, 5'd1: clr = 1'b1;
          5'd2:       clr = ent_q[i].g;
          5'd3:       clr = !ent_q[i].g;
          5'd4:       clr = !ent_q[i].g && asid_m[1][i];
          5'd5:       clr = !ent_q[i].g && asid_m[1][i] && va_m[1][i];
          5'd6:       clr = (ent_q[i].g || asid_m[1][i]) && va_m[1][i];
          default:    clr = 1'b0;
        endcase
        if (clr) ent_d[i].e = 1'b0;
      end
    end
    if (we) begin
      ent_d[w_index].e    = w_e;
      ent_d[w_index].g    = w_g;
      ent_d[w_index].vppn = w_vppn;
      ent_d[w_index].ps   = w_ps;
      ent_d[w_index].asid = w_asid;
      ent_d[w_index].p0   = '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0};
      ent_d[w_index].p1   = '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign r_e    = ent_q[r_index].e;
  assign r_g    = ent_q[r_index].g;
  assign r_vppn = ent_q[r_index].vppn;
  assign r_ps   = ent_q[r_index].ps;
  assign r_asid = ent_q[r_index].asid;
  assign r_ppn0 = ent_q[r_index].p0.ppn;
  assign r_plv0 = ent_q[r_index].p0.plv;
  assign r_mat0 = ent_q[r_index].p0.mat;
  assign r_d0   = ent_q[r_index].p0.d;
  assign r_v0   = ent_q[r_index].p0.v;
  assign r_ppn1 = ent_q[r_index].p1.ppn;
  assign r_plv1 = ent_q[r_index].p1.plv;
  assign r_mat1 = ent_q[r_index].p1.mat;
  assign r_d1   = ent_q[r_index].p1.d;
  assign r_v1   = ent_q[r_index].p1.v;

endmodule
